// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises and glitch-filters A/B/index,
// decodes Gray-code transitions into single-cycle step pulses with direction,
// issues an index load request and keeps a sticky illegal-transition flag.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic enc_idx,
    input  logic index_en,
    input  logic err_clr,
    output logic step_en,
    output logic step_up,
    output logic load_req,
    output logic err,
    output logic tracking
);
    localparam int CW  = $clog2(FILTER_LEN + 1);
    localparam int WW  = $clog2(SYNC_STAGES + 1);
    localparam int NCH = 3;  // bit 0 = A, bit 1 = B, bit 2 = IDX

    typedef enum logic {
        INIT,
        TRACK
    } state_e;

    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] sync_d [SYNC_STAGES];
    logic [NCH-1:0] filt_q, filt_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [NCH-1:0] prev_q, prev_d;   // filtered levels one cycle earlier
    logic [WW-1:0]  warm_q, warm_d;   // edges since reset, saturating at SYNC_STAGES
    state_e         state_q, state_d;
    logic           step_en_q, step_en_d;
    logic           step_up_q, step_up_d;
    logic           load_req_q, load_req_d;
    logic           err_q, err_d;

    logic [NCH-1:0] sync_out;
    logic           settled;
    logic           a_chg, b_chg, legal, illegal, up_edge;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Per-bit change detection between the previous and current filtered A/B levels.
    assign a_chg   = filt_q[0] ^ prev_q[0];
    assign b_chg   = filt_q[1] ^ prev_q[1];
    assign legal   = a_chg ^ b_chg;
    assign illegal = a_chg & b_chg;
    // A moving while A==B, or B moving while A!=B, is the A-leads-B (up) direction.
    assign up_edge = (a_chg & ~(prev_q[0] ^ prev_q[1])) | (b_chg & (prev_q[0] ^ prev_q[1]));

    // Synchroniser shift: raw inputs enter stage 0 and move one stage per cycle.
    always_comb begin
        sync_d[0] = {enc_idx, enc_b, enc_a};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Glitch filter: accept a new level only after FILTER_LEN consecutive differing samples.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path can leave a latch behind.
        filt_d = filt_q;
        for (int c = 0; c < NCH; c++) begin
            cnt_d[c] = '0;
            if (sync_out[c] != filt_q[c]) begin
                if (cnt_q[c] == CW'(FILTER_LEN - 1)) begin
                    filt_d[c] = sync_out[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CW'(1);
                end
            end
        end
    end

    // Settle check: sync chain flushed since reset, no filter mid-count, sync agrees with filtered level.
    always_comb begin
        settled = (sync_out == filt_q) && (warm_q == WW'(SYNC_STAGES));
        for (int c = 0; c < NCH; c++) begin
            if (cnt_q[c] != '0) begin
                settled = 1'b0;
            end
        end
    end

    // Decoder FSM next state and registered outputs.
    always_comb begin
        state_d    = state_q;
        step_en_d  = 1'b0;
        step_up_d  = step_up_q;
        load_req_d = 1'b0;
        err_d      = err_q & ~err_clr;
        prev_d     = filt_q;
        warm_d     = warm_q;
        if (warm_q != WW'(SYNC_STAGES)) begin
            warm_d = warm_q + WW'(1);
        end
        case (state_q)
            INIT: begin
                if (settled) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (legal) begin
                    step_en_d = 1'b1;
                    step_up_d = up_edge;
                end
                if (illegal) begin
                    err_d = 1'b1;  // set wins over err_clr
                end
                if (index_en && !prev_q[2] && filt_q[2]) begin
                    load_req_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State register; every flop, including the synchroniser array, has an async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the synchroniser array is reset too, because the INIT settle check reads its contents.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
            end
            filt_q     <= '0;
            prev_q     <= '0;
            warm_q     <= '0;
            state_q    <= INIT;
            step_en_q  <= 1'b0;
            step_up_q  <= 1'b1;
            load_req_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            warm_q     <= warm_d;
            state_q    <= state_d;
            step_en_q  <= step_en_d;
            step_up_q  <= step_up_d;
            load_req_q <= load_req_d;
            err_q      <= err_d;
        end
    end

    assign step_en  = step_en_q;
    assign step_up  = step_up_q;
    assign load_req = load_req_q;
    assign err      = err_q;
    assign tracking = (state_q == TRACK);

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder with a sample-window reference model.
module tb_quad_step_decoder;
    localparam int S  = 2;
    localparam int FL = 3;

    logic clk = 1'b0;
    logic reset, enc_a, enc_b, enc_idx, index_en, err_clr;
    logic step_en, step_up, load_req, err, tracking;

    int vectors     = 0;
    int miscompares = 0;
    int step_cnt    = 0;
    int load_cnt    = 0;

    quad_step_decoder #(.SYNC_STAGES(S), .FILTER_LEN(FL)) dut (
        .clk      (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .enc_idx  (enc_idx),
        .index_en (index_en),
        .err_clr  (err_clr),
        .step_en  (step_en),
        .step_up  (step_up),
        .load_req (load_req),
        .err      (err),
        .tracking (tracking)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw samples delayed S edges, a level flips once the last FL
    // delayed samples all disagree with it, and steps come from quadrant arithmetic.
    bit [2:0] dly[$];
    bit [2:0] win[$];
    bit [2:0] lvl, lvl_prev;
    bit       m_track, e_step, e_up, e_load, e_err;
    int       n_edge;

    function automatic int gpos(bit a, bit b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        dly = {};
        for (int i = 0; i < S; i++) dly.push_back(3'b000);
        win = {};
        lvl = '0; lvl_prev = '0;
        m_track = 0; e_step = 0; e_up = 1; e_load = 0; e_err = 0; n_edge = 0;
    endtask

    task automatic model_edge();
        bit [2:0] seen, nl;
        bit       set_err, all_diff;
        int       d;
        n_edge++;
        seen = dly.pop_front();
        dly.push_back({enc_idx, enc_b, enc_a});
        e_step = 0; e_load = 0; set_err = 0;
        if (m_track) begin
            d = (gpos(lvl[0], lvl[1]) - gpos(lvl_prev[0], lvl_prev[1]) + 4) % 4;
            if (d == 1) begin e_step = 1; e_up = 1; end
            if (d == 3) begin e_step = 1; e_up = 0; end
            if (d == 2) set_err = 1;
            if (!lvl_prev[2] && lvl[2] && index_en) e_load = 1;
        end
        e_err = set_err | (e_err & !err_clr);
        win.push_back(seen);
        if (win.size() > FL) void'(win.pop_front());
        nl = lvl;
        if (win.size() == FL) begin
            for (int c = 0; c < 3; c++) begin
                all_diff = 1;
                foreach (win[i]) if (win[i][c] == lvl[c]) all_diff = 0;
                if (all_diff) nl[c] = ~lvl[c];
            end
        end
        lvl_prev = lvl;
        lvl      = nl;
        if (!m_track && n_edge >= S + 1 && seen == lvl && lvl == lvl_prev) m_track = 1;
    endtask

    // Compare process: checks every output against the model just after each edge.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            model_reset();
            check("rst_step_en", step_en, 0);
            check("rst_step_up", step_up, 1);
            check("rst_load_req", load_req, 0);
            check("rst_err", err, 0);
            check("rst_tracking", tracking, 0);
        end else begin
            model_edge();
            check("step_en", step_en, e_step);
            check("step_up", step_up, e_up);
            check("load_req", load_req, e_load);
            check("err", err, e_err);
            if (step_en === 1'b1) step_cnt++;
            if (load_req === 1'b1) load_cnt++;
        end
    end

    task automatic set_in(input bit a, input bit b, input bit idx);
        @(negedge clk);
        enc_a = a; enc_b = b; enc_idx = idx;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edges from the capturing edge (0) until the chosen pulse appears; -1 if never.
    task automatic measure(input bit want_load, output int lat);
        lat = -1;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk);
            #1;
            if ((want_load ? load_req : step_en) === 1'b1) begin
                lat = j;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int s0, l0, lat, found;
        bit [1:0] up_seq [4];
        bit [1:0] dn_seq [4];
        up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        dn_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        reset = 1; enc_a = 0; enc_b = 0; enc_idx = 0; index_en = 0; err_clr = 0;
        idle(3);
        check("reset_tracking", tracking, 0);
        check("reset_step_up", step_up, 1);
        reset = 0;
        idle(20);
        check("init_to_track", tracking, 1);

        // 1: up sequence
        s0 = step_cnt;
        for (int i = 0; i < 4; i++) begin
            set_in(up_seq[i][1], up_seq[i][0], 0);
            measure(0, lat);
            check("up_latency", lat, 5);
            check("up_dir", step_up, 1);
            idle(8);
        end
        check("up_count", step_cnt - s0, 4);
        check("up_err", err, 0);

        // 2: reverse sequence, then one up step
        s0 = step_cnt;
        for (int i = 0; i < 4; i++) begin
            set_in(dn_seq[i][1], dn_seq[i][0], 0);
            measure(0, lat);
            check("dn_latency", lat, 5);
            check("dn_dir", step_up, 0);
            idle(8);
        end
        check("dn_count", step_cnt - s0, 4);
        set_in(1, 0, 0);
        measure(0, lat);
        check("up_again_latency", lat, 5);
        check("up_again_dir", step_up, 1);
        set_in(0, 0, 0);
        idle(12);

        // 3: glitches of 2 and 3 cycles on A
        s0 = step_cnt;
        @(negedge clk); enc_a = 1;
        idle(2);        enc_a = 0;
        idle(12);
        check("glitch2_steps", step_cnt - s0, 0);
        @(negedge clk); enc_a = 1;
        idle(3);        enc_a = 0;
        idle(15);
        check("glitch3_steps", step_cnt - s0, 2);

        // 4: illegal jumps and err_clr priority
        s0 = step_cnt;
        set_in(1, 1, 0);
        idle(10);
        check("illegal_err", err, 1);
        check("illegal_no_step", step_cnt - s0, 0);
        set_in(0, 0, 0);
        idle(5);
        err_clr = 1;
        idle(1);
        err_clr = 0;
        check("err_set_wins", err, 1);
        idle(3);
        err_clr = 1;
        idle(1);
        err_clr = 0;
        check("err_cleared", err, 0);
        idle(5);

        // 5: index load requests
        index_en = 1;
        l0 = load_cnt;
        set_in(0, 0, 1);
        measure(1, lat);
        check("index_latency", lat, 5);
        idle(10);
        set_in(0, 0, 0);
        idle(10);
        check("index_one_pulse", load_cnt - l0, 1);
        l0 = load_cnt;
        index_en = 0;
        set_in(0, 0, 1);
        idle(10);
        index_en = 1;
        idle(10);
        check("index_disabled", load_cnt - l0, 0);
        set_in(0, 0, 0);
        idle(10);
        check("index_fall", load_cnt - l0, 0);
        set_in(1, 0, 1);
        measure(1, lat);
        check("coincident_latency", lat, 5);
        check("coincident_step", step_en, 1);
        check("coincident_dir", step_up, 1);
        idle(10);
        set_in(1, 0, 0);
        idle(10);

        // 6: reset during a down burst ending at 11
        set_in(0, 0, 0); idle(8);
        set_in(0, 1, 0); idle(8);
        check("pre_reset_dir", step_up, 0);
        set_in(1, 1, 0);
        idle(3);
        reset = 1;
        #1;
        check("async_step_en", step_en, 0);
        check("async_step_up", step_up, 1);
        check("async_tracking", tracking, 0);
        idle(3);
        reset = 0;
        s0 = step_cnt;
        idle(1);
        check("post_reset_init", tracking, 0);
        found = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (tracking === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("post_reset_track", found, 1);
        idle(10);
        check("post_reset_no_step", step_cnt - s0, 0);
        check("post_reset_no_err", err, 0);
        set_in(0, 1, 0);
        measure(0, lat);
        check("post_reset_latency", lat, 5);
        check("post_reset_dir", step_up, 1);
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
